// File: rtl/edge_packet_injector.sv
// rtl/edge_packet_injector.sv - credit-throttled, duty-cycled packet source for one core edge port
module edge_packet_injector #(
    parameter int X_WIDTH       = 5,
    parameter int ADDR_BITS     = 3,
    parameter int SERIAL_BITS   = 16,
    parameter int TRAFFIC       = 10,
    parameter int TRAFFIC_PHASE = 0,
    parameter int START_INDEX   = 0,
    parameter int BUFFER_DEPTH  = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start_din,
    input  logic [SERIAL_BITS-1:0]               quota_din,
    input  logic                                 credit_din,
    output logic [4*ADDR_BITS+SERIAL_BITS-1:0]   channel_dout,
    output logic                                 valid_dout,
    output logic                                 busy_dout,
    output logic                                 done_dout,
    output logic [SERIAL_BITS-1:0]               sent_count_dout,
    output logic                                 credit_error_dout
);

    localparam int CW = $clog2(BUFFER_DEPTH + 1);
    localparam logic [3:0]    TRAFFIC_L = 4'(TRAFFIC);
    localparam logic [3:0]    PHASE_L   = 4'(TRAFFIC_PHASE);
    localparam logic [3:0]    INDEX_L   = 4'(START_INDEX);
    localparam logic [CW-1:0] DEPTH_L   = CW'(BUFFER_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state, state_nxt;
    logic [3:0]              arb, idx;
    logic [SERIAL_BITS-1:0]  quota, serial, sent;
    logic [CW-1:0]           credits;
    logic                    inject, last_inject;
    logic [ADDR_BITS-1:0]    def_x, def_y, gate_x, gate_y;

    assign inject          = (state == RUN) && (arb < TRAFFIC_L) && (credits != '0);
    assign last_inject     = inject && ((sent + SERIAL_BITS'(1)) == quota);
    assign sent_count_dout = sent;

    // Destination table; the x range 1..X_WIDTH is baked into the constants.
    always_comb begin
        def_x  = ADDR_BITS'(1);
        gate_y = ADDR_BITS'(1);
        case (idx)
            4'd0:    begin def_x = ADDR_BITS'(1);       gate_y = ADDR_BITS'(1); end
            4'd1:    begin def_x = ADDR_BITS'(X_WIDTH); gate_y = ADDR_BITS'(2); end
            4'd2:    begin def_x = ADDR_BITS'(2);       gate_y = ADDR_BITS'(3); end
            4'd3:    begin def_x = ADDR_BITS'(4);       gate_y = ADDR_BITS'(4); end
            4'd4:    begin def_x = ADDR_BITS'(3);       gate_y = ADDR_BITS'(5); end
            4'd5:    begin def_x = ADDR_BITS'(3);       gate_y = ADDR_BITS'(5); end
            4'd6:    begin def_x = ADDR_BITS'(4);       gate_y = ADDR_BITS'(4); end
            4'd7:    begin def_x = ADDR_BITS'(2);       gate_y = ADDR_BITS'(3); end
            4'd8:    begin def_x = ADDR_BITS'(X_WIDTH); gate_y = ADDR_BITS'(2); end
            4'd9:    begin def_x = ADDR_BITS'(1);       gate_y = ADDR_BITS'(1); end
            default: begin def_x = ADDR_BITS'(1);       gate_y = ADDR_BITS'(1); end
        endcase
        def_y  = idx[0] ? ADDR_BITS'(6) : ADDR_BITS'(0);
        gate_x = idx[0] ? ADDR_BITS'(X_WIDTH) : ADDR_BITS'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_din) state_nxt = (quota_din == '0) ? DONE : RUN;
            RUN:  if (last_inject) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_dout = (state == RUN);
        done_dout = (state == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quota             <= '0;
            arb               <= PHASE_L;
            idx               <= INDEX_L;
            serial            <= '0;
            sent              <= '0;
            credits           <= DEPTH_L;
            channel_dout      <= '0;
            valid_dout        <= 1'b0;
            credit_error_dout <= 1'b0;
        end else begin
            if (state == IDLE && start_din) begin
                quota  <= quota_din;
                arb    <= PHASE_L;
                idx    <= INDEX_L;
                serial <= '0;
                sent   <= '0;
            end else if (state == RUN) begin
                arb <= (arb == 4'd9) ? 4'd0 : arb + 4'd1;
                idx <= (idx == 4'd9) ? 4'd0 : idx + 4'd1;
            end

            valid_dout <= inject;
            if (inject) begin
                channel_dout <= {def_x, def_y, gate_x, gate_y, serial};
                serial       <= serial + SERIAL_BITS'(1);
                sent         <= sent + SERIAL_BITS'(1);
            end

            // A return with no matching consumption at full credit means the router over-credited us.
            case ({inject, credit_din})
                2'b10: credits <= credits - CW'(1);
                2'b01: begin
                    if (credits == DEPTH_L) credit_error_dout <= 1'b1;
                    else                    credits <= credits + CW'(1);
                end
                default: credits <= credits;
            endcase
        end
    end

endmodule

// File: doc/edge_packet_injector.md
# edge_packet_injector

Synthesizable traffic source for one edge port of the test-engine network core, and the block that sits directly upstream of a core input channel. On a start pulse it emits a configurable number of network-directed packets, each carrying a deflector address, a gate address and a serial number. Injection follows a 10-slot duty cycle and is throttled by credits returned from the router input buffer. It replaces bench-only packet sources when the core is exercised on silicon or in gate-level runs.

## Interface
- `X_WIDTH`, default 5: nodes per row. Fixes the address range that the destination table uses.
- `ADDR_BITS`, default 3: width of each of the four address fields.
- `SERIAL_BITS`, default 16: width of the serial field and of the sent counter.
- `TRAFFIC`, default 10: number of injection slots per 10-cycle window, range 0..10.
- `TRAFFIC_PHASE`, default 0: reset and start value of the slot arbiter, range 0..9.
- `START_INDEX`, default 0: starting entry in the destination table, range 0..9.
- `BUFFER_DEPTH`, default 4: credits available after reset, which equals the router input buffer depth.
- `clk` input 1: system clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start_din` input 1: pulse that begins a run. Sampled only in IDLE.
- `quota_din` input SERIAL_BITS: number of packets to send. Latched on start.
- `credit_din` input 1: one-cycle pulse meaning one router buffer slot was freed.
- `channel_dout` output 4*ADDR_BITS+SERIAL_BITS: packet word {def_x, def_y, gate_x, gate_y, serial}, with def_x in the MSBs.
- `valid_dout` output 1: `channel_dout` holds a new packet this cycle.
- `busy_dout` output 1: high in RUN.
- `done_dout` output 1: one-cycle pulse at the end of a run.
- `sent_count_dout` output SERIAL_BITS: packets sent in the current or last run.
- `credit_error_dout` output 1: sticky overflow flag.

## Operation
- FSM states are IDLE, RUN and DONE.
  - IDLE → RUN when `start_din`=1. On that edge:
    - latch the quota;
    - arbiter ← TRAFFIC_PHASE, index ← START_INDEX;
    - serial ← 0, sent ← 0.
  - IDLE with `start_din`=1 and quota=0 → DONE directly. No packet is sent.
  - RUN → DONE on the edge where the injection that makes sent equal the quota is registered.
  - DONE → IDLE unconditionally after 1 cycle. `done_dout`=1 only while in DONE.
- Destination table: 10 entries, index i = 0..9.
  - def_x = {1,5,2,4,3,3,4,2,5,1}[i]
  - def_y = 0 for even i, 6 for odd i
  - gate_x = 1 for even i, 5 for odd i
  - gate_y = {1,2,3,4,5,5,4,3,2,1}[i]
- Injection condition in RUN: inject = (arbiter < TRAFFIC) && (credits > 0).
- Every RUN cycle, whether or not a packet is injected:
  - arbiter ← (arbiter+1) mod 10;
  - index ← (index+1) mod 10.
- A slot that is allowed by the arbiter but blocked by zero credits is lost. It is not retried.
- On inject:
  - `channel_dout` ← {table[index], serial};
  - `valid_dout` ← 1;
  - serial += 1, sent += 1, with modulo 2^SERIAL_BITS wrap.
- Without an inject: `valid_dout` ← 0 and `channel_dout` holds its last value.
- Credits:
  - reset value is BUFFER_DEPTH;
  - decrement on inject, increment on `credit_din`;
  - both in the same cycle: credits unchanged.
- Credit overflow: a `credit_din` pulse when credits = BUFFER_DEPTH and there is no inject leaves credits saturated and sets `credit_error_dout`.
  - The flag clears only on reset.
- Credits are tracked in every state, so credits still returning after DONE are counted.
- `start_din` outside IDLE is ignored.
- `sent_count_dout` holds its value through IDLE until the next start.

## Timing
- Reset values:
  - state IDLE; `valid_dout`, `busy_dout`, `done_dout`, `credit_error_dout` all 0;
  - `channel_dout` 0, `sent_count_dout` 0;
  - credits BUFFER_DEPTH, arbiter TRAFFIC_PHASE, index START_INDEX.
- Latency: `start_din` is sampled at edge k. `busy_dout` is high after edge k. The earliest `valid_dout` is high after edge k+1.
- All outputs are registered. There is no combinational path from an input to an output.
- A credit arriving at edge m can enable an inject at edge m+1, not at edge m.
- Reset asserted mid-run: all state returns to its reset value immediately. `valid_dout` drops without waiting for the clock. The partial run is abandoned.
- Last packet: `valid_dout` for the packet that completes the quota is high in the same cycle that `done_dout` goes high.

## Test plan
- TRAFFIC=10, credits returned every cycle, quota=12, START_INDEX=0:
  - 12 consecutive valid cycles, serials 0..11;
  - first word def(1,0), gate(1,1); 11th word (serial 10) def(1,0) again, showing index wrap;
  - `done_dout` pulses with the 12th valid; sent=12.
- TRAFFIC=7, TRAFFIC_PHASE=0, credits unlimited, quota=14:
  - valid pattern of 7 high then 3 low, repeated;
  - serials stay contiguous; the run ends after 17 valid-window cycles (10+7).
- No `credit_din`, BUFFER_DEPTH=4, TRAFFIC=10, quota=6:
  - exactly 4 packets, then stall with busy high;
  - two credit pulses → 2 more packets, then done.
- Simultaneous inject and `credit_din` at credits=1 → credits stay 1 and injection continues. A `credit_din` while idle at full credits → `credit_error_dout`=1, sticky.
- quota=0 start → no valid, `done_dout` one cycle after start, sent=0. A second `start_din` pulse during RUN → no effect on quota or serial.
- Assert reset after 3 packets of a quota=10 run → outputs return to reset values asynchronously. A new start with quota=2 → serials 0 and 1, first word from START_INDEX.
